// File: rtl/wb_host_master.sv
// Wishbone classic (B4) single-outstanding initiator: turns a valid/ready command
// stream into bus cycles and returns one response per command, with a wait-cycle abort.
module wb_host_master #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TW      = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,

    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_adr,
    input  logic [31:0] cmd_dat,
    input  logic [3:0]  cmd_sel,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_dat,
    output logic        rsp_err,

    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [TW-1:0] LAST_WAIT = TW'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [TW-1:0] wait_cnt_q;
    logic          cmd_fire;
    logic          bus_ack;
    logic          bus_timeout;

    assign cmd_fire    = (state_q == IDLE) && cmd_valid;
    assign bus_ack     = (state_q == BUS) && wbm_ack_i;
    // An ack arriving on the final wait cycle still completes the transfer normally.
    assign bus_timeout = (state_q == BUS) && !wbm_ack_i && (wait_cnt_q == LAST_WAIT);

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        wbm_cyc_o = 1'b0;
        wbm_stb_o = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_d = BUS;
                end
            end
            BUS: begin
                wbm_cyc_o = 1'b1;
                wbm_stb_o = 1'b1;
                if (bus_ack || bus_timeout) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            wbm_we_o   <= 1'b0;
            wbm_adr_o  <= '0;
            wbm_dat_o  <= '0;
            wbm_sel_o  <= '0;
            rsp_dat    <= '0;
            rsp_err    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (cmd_fire) begin
                wbm_we_o   <= cmd_we;
                wbm_adr_o  <= cmd_adr;
                wbm_dat_o  <= cmd_dat;
                wbm_sel_o  <= cmd_sel;
                wait_cnt_q <= '0;
            end
            // Response fields change only when leaving BUS, so they hold through RESP.
            if (bus_ack) begin
                rsp_dat <= wbm_we_o ? 32'd0 : wbm_dat_i;
                rsp_err <= 1'b0;
            end else if (bus_timeout) begin
                rsp_dat <= 32'd0;
                rsp_err <= 1'b1;
            end else if (state_q == BUS) begin
                wait_cnt_q <= wait_cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wb_host_master.sv
// Directed self-checking bench for wb_host_master, built with TIMEOUT=8 so the
// timeout boundary is reachable in a handful of cycles.
module tb_wb_host_master;

    localparam int TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_adr, cmd_dat;
    logic [3:0]  cmd_sel;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_dat;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
    logic [3:0]  wbm_sel_o;
    logic        wbm_ack_i;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_host_master #(.TIMEOUT(TIMEOUT), .TW(16)) dut (
        .wb_clk_i (clk),
        .wb_rst_ni(rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_we   (cmd_we),
        .cmd_adr  (cmd_adr),
        .cmd_dat  (cmd_dat),
        .cmd_sel  (cmd_sel),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_dat  (rsp_dat),
        .rsp_err  (rsp_err),
        .wbm_cyc_o(wbm_cyc_o),
        .wbm_stb_o(wbm_stb_o),
        .wbm_we_o (wbm_we_o),
        .wbm_adr_o(wbm_adr_o),
        .wbm_dat_o(wbm_dat_o),
        .wbm_sel_o(wbm_sel_o),
        .wbm_dat_i(wbm_dat_i),
        .wbm_ack_i(wbm_ack_i)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one command, play the slave (ack after ack_after waits, -1 = never), and
    // return once rsp_valid is seen. lat counts cycles from the handshake edge.
    task automatic run_txn(input string tag, input logic we, input logic [31:0] adr,
                           input logic [31:0] dat, input logic [3:0] sel,
                           input int ack_after, input logic [31:0] sdata,
                           output int stb_cnt, output int lat, output logic stable);
        check({tag, ".cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_dat   = dat;
        cmd_sel   = sel;
        tick();
        cmd_valid = 1'b0;
        cmd_adr   = 32'hFFFF_FFFF;
        cmd_dat   = 32'hFFFF_FFFF;
        cmd_sel   = 4'hF;
        cmd_we    = ~we;
        lat     = 1;
        stb_cnt = 0;
        stable  = 1'b1;
        while (!rsp_valid && lat < 40) begin
            if (wbm_stb_o) begin
                if (wbm_cyc_o !== 1'b1 || wbm_adr_o !== adr || wbm_dat_o !== dat ||
                    wbm_sel_o !== sel || wbm_we_o !== we)
                    stable = 1'b0;
                if (stb_cnt == ack_after) begin
                    wbm_ack_i = 1'b1;
                    wbm_dat_i = sdata;
                end
                stb_cnt++;
            end
            tick();
            wbm_ack_i = 1'b0;
            wbm_dat_i = 32'hDEAD_BEEF;
            lat++;
        end
        check({tag, ".rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
        check({tag, ".bus_stable"}, {31'd0, stable}, 32'd1);
        check({tag, ".cyc_low_in_resp"}, {31'd0, wbm_cyc_o}, 32'd0);
    endtask

    task automatic consume(input string tag);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check({tag, ".rsp_dropped"}, {31'd0, rsp_valid}, 32'd0);
        check({tag, ".cmd_ready_back"}, {31'd0, cmd_ready}, 32'd1);
    endtask

    initial begin
        int   stb_cnt, lat;
        logic stable;
        logic bad_valid, bad_ready, bad_cyc, bad_dat;

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_adr   = '0;
        cmd_dat   = '0;
        cmd_sel   = '0;
        rsp_ready = 1'b0;
        wbm_ack_i = 1'b0;
        wbm_dat_i = 32'hDEAD_BEEF;
        tick();
        tick();
        rst_n = 1'b1;

        check("reset.cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("reset.rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset.rsp_err",   {31'd0, rsp_err},   32'd0);
        check("reset.rsp_dat",   rsp_dat,            32'd0);
        check("reset.cyc_stb",   {30'd0, wbm_cyc_o, wbm_stb_o}, 32'd0);
        check("reset.we",        {31'd0, wbm_we_o},  32'd0);
        check("reset.adr",       wbm_adr_o,          32'd0);
        check("reset.dat",       wbm_dat_o,          32'd0);
        check("reset.sel",       {28'd0, wbm_sel_o}, 32'd0);

        // Zero-wait read.
        run_txn("rd0", 1'b0, 32'h3000_0004, 32'h0, 4'hF, 0, 32'hA5A5_1234, stb_cnt, lat, stable);
        check("rd0.stb_cycles", stb_cnt, 32'd1);
        check("rd0.latency",    lat,     32'd2);
        check("rd0.rsp_dat",    rsp_dat, 32'hA5A5_1234);
        check("rd0.rsp_err",    {31'd0, rsp_err}, 32'd0);
        consume("rd0");

        // Write with three wait states; slave drives junk data that must not leak into the response.
        run_txn("wr3", 1'b1, 32'h3000_0010, 32'hCAFE_F00D, 4'b0011, 3, 32'h1234_5678, stb_cnt, lat, stable);
        check("wr3.stb_cycles", stb_cnt, 32'd4);
        check("wr3.latency",    lat,     32'd5);
        check("wr3.rsp_dat",    rsp_dat, 32'd0);
        check("wr3.rsp_err",    {31'd0, rsp_err}, 32'd0);
        consume("wr3");

        // Slave never acks: abort after exactly TIMEOUT strobe cycles.
        run_txn("to", 1'b0, 32'h3000_0020, 32'h0, 4'hF, -1, 32'h0, stb_cnt, lat, stable);
        check("to.stb_cycles", stb_cnt, TIMEOUT);
        check("to.latency",    lat,     TIMEOUT + 1);
        check("to.rsp_dat",    rsp_dat, 32'd0);
        check("to.rsp_err",    {31'd0, rsp_err}, 32'd1);
        consume("to");

        // A late ack while idle must produce nothing.
        bad_valid = 1'b0;
        bad_cyc   = 1'b0;
        wbm_ack_i = 1'b1;
        wbm_dat_i = 32'h5555_5555;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (rsp_valid) bad_valid = 1'b1;
            if (wbm_cyc_o) bad_cyc = 1'b1;
        end
        wbm_ack_i = 1'b0;
        wbm_dat_i = 32'hDEAD_BEEF;
        check("late_ack.no_rsp", {31'd0, bad_valid}, 32'd0);
        check("late_ack.no_cyc", {31'd0, bad_cyc},   32'd0);
        check("late_ack.ready",  {31'd0, cmd_ready}, 32'd1);

        // Ack on the last allowed cycle wins over the timeout.
        run_txn("edge", 1'b0, 32'h3000_0030, 32'h0, 4'hF, TIMEOUT - 1, 32'h1, stb_cnt, lat, stable);
        check("edge.stb_cycles", stb_cnt, TIMEOUT);
        check("edge.rsp_dat",    rsp_dat, 32'h1);
        check("edge.rsp_err",    {31'd0, rsp_err}, 32'd0);
        consume("edge");

        // Response back-pressure with a new command already waiting.
        run_txn("bp", 1'b0, 32'h3000_0040, 32'h0, 4'hF, 0, 32'h0BAD_CAFE, stb_cnt, lat, stable);
        cmd_valid = 1'b1;
        cmd_adr   = 32'h3000_0044;
        bad_valid = 1'b0;
        bad_ready = 1'b0;
        bad_cyc   = 1'b0;
        bad_dat   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (!rsp_valid) bad_valid = 1'b1;
            if (cmd_ready) bad_ready = 1'b1;
            if (wbm_cyc_o || wbm_stb_o) bad_cyc = 1'b1;
            if (rsp_dat !== 32'h0BAD_CAFE || rsp_err !== 1'b0) bad_dat = 1'b1;
        end
        cmd_valid = 1'b0;
        check("bp.valid_held",  {31'd0, bad_valid}, 32'd0);
        check("bp.no_ready",    {31'd0, bad_ready}, 32'd0);
        check("bp.no_bus",      {31'd0, bad_cyc},   32'd0);
        check("bp.data_stable", {31'd0, bad_dat},   32'd0);
        consume("bp");

        // Reset during the second BUS cycle discards the transaction.
        cmd_valid = 1'b1;
        cmd_we    = 1'b1;
        cmd_adr   = 32'h3000_0050;
        cmd_dat   = 32'h7777_7777;
        cmd_sel   = 4'hF;
        tick();
        cmd_valid = 1'b0;
        check("rst_mid.bus1", {31'd0, wbm_stb_o}, 32'd1);
        tick();
        check("rst_mid.bus2", {31'd0, wbm_stb_o}, 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rst_mid.cyc_stb", {30'd0, wbm_cyc_o, wbm_stb_o}, 32'd0);
        check("rst_mid.adr",     wbm_adr_o, 32'd0);
        check("rst_mid.ready",   {31'd0, cmd_ready}, 32'd1);
        bad_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (rsp_valid) bad_valid = 1'b1;
            tick();
        end
        check("rst_mid.no_rsp", {31'd0, bad_valid}, 32'd0);

        run_txn("post", 1'b0, 32'h3000_0060, 32'h0, 4'h5, 1, 32'h600D_D00D, stb_cnt, lat, stable);
        check("post.latency", lat,     32'd3);
        check("post.rsp_dat", rsp_dat, 32'h600D_D00D);
        check("post.rsp_err", {31'd0, rsp_err}, 32'd0);
        consume("post");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
